// File: rtl/run_controller_if.sv
// Program-load stream and instruction-memory write port between the harness and
// the run controller. The master side is the harness, the slave side the controller.
interface run_controller_if #(
   parameter int unsigned ADDR_WIDTH = 6
);
   logic                  load_valid;
   logic [31:0]           load_data;
   logic                  load_last;
   logic                  load_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      output load_valid, load_data, load_last,
      input  load_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  load_valid, load_data, load_last,
      output load_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/run_controller.sv
// Run-control sequencer: loads a program into IMEM with the core held in reset,
// then gates PC updates for run/halt/step/breakpoint and counts executed cycles.
module run_controller #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned IMEM_DEPTH = 64,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cmd_load,
   input  logic                 cmd_run,
   input  logic                 cmd_halt,
   input  logic                 cmd_step,
   run_controller_if.slave      bus,
   input  logic                 bp_en,
   input  logic [31:0]          bp_addr,
   input  logic [31:0]          pc_value,
   output logic                 core_rst,
   output logic                 pc_en,
   output logic [2:0]           state,
   output logic                 halted,
   output logic                 load_error,
   output logic [CNT_WIDTH-1:0] cycle_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMEM_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RUN  = 3'd2,
      S_HALT = 3'd3,
      S_STEP = 3'd4
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] ptr_q;
   logic                  pc_gate_q;
   logic                  run_entry_q;
   logic                  handshake;
   logic                  bp_hit;
   logic                  load_entry;
   logic                  err_set;

   assign state     = state_q;
   assign handshake = bus.load_valid & bus.load_ready;
   // Matching is masked on the first RUN cycle so a resume from a breakpoint PC proceeds.
   assign bp_hit    = (state_q == S_RUN) & ~run_entry_q & bp_en & (pc_value == bp_addr);
   assign pc_en     = pc_gate_q & ~bp_hit;

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      load_entry = 1'b0;
      err_set    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_load) begin
               state_d    = S_LOAD;
               load_entry = 1'b1;
            end
         end
         S_LOAD: begin
            if (handshake) begin
               if (bus.load_last) begin
                  state_d = S_HALT;
               end else if (ptr_q == LAST_ADDR) begin
                  state_d = S_HALT;
                  err_set = 1'b1;
               end
            end
         end
         S_HALT: begin
            if (cmd_halt) begin
               state_d = S_HALT;
            end else if (cmd_step) begin
               state_d = S_STEP;
            end else if (cmd_run) begin
               state_d = S_RUN;
            end else if (cmd_load) begin
               state_d    = S_LOAD;
               load_entry = 1'b1;
            end
         end
         S_RUN: begin
            if (cmd_halt | cmd_step | bp_hit) begin
               state_d = S_HALT;
            end
         end
         S_STEP: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // State register and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q        <= S_IDLE;
         core_rst       <= 1'b1;
         pc_gate_q      <= 1'b0;
         run_entry_q    <= 1'b0;
         bus.load_ready <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         halted         <= 1'b0;
         load_error     <= 1'b0;
         cycle_count    <= '0;
         ptr_q          <= '0;
      end else begin
         state_q        <= state_d;
         core_rst       <= (state_q == S_IDLE) | (state_q == S_LOAD);
         pc_gate_q      <= (state_d == S_RUN) | (state_d == S_STEP);
         run_entry_q    <= (state_q == S_HALT) & (state_d == S_RUN);
         bus.load_ready <= (state_d == S_LOAD);
         halted         <= (state_d == S_HALT);
         bus.imem_we    <= handshake;
         if (handshake) begin
            bus.imem_addr  <= ptr_q;
            bus.imem_wdata <= bus.load_data;
            ptr_q          <= ptr_q + ADDR_WIDTH'(1);
         end
         if (load_entry) begin
            ptr_q       <= '0;
            load_error  <= 1'b0;
            cycle_count <= '0;
         end else if (pc_en) begin
            cycle_count <= cycle_count + CNT_WIDTH'(1);
         end
         if (err_set) begin
            load_error <= 1'b1;
         end
      end
   end

endmodule
